// File: rtl/cgb_palette_file.sv
// Purpose: CGB colour-palette store, NUM_BANKS banks of CPU spec/data register pairs plus a PPU lookup port per bank.
// Latency: CPU reads are combinational; PPU lookups are registered (request at N, colour/valid at N+1).
// Backpressure: none; PPU mode-3 lock drops data writes; optional clear sequencer (PAL_INIT_CLEAR_EN) drops data writes while busy.
module cgb_palette_file #(
    parameter int          NUM_BANKS      = 2,
    parameter int          PAL_COUNT      = 8,
    parameter int          COLORS_PER_PAL = 4,
    parameter logic [15:0] BASE_ADDR      = 16'hFF68,
    localparam int         ENTRIES        = PAL_COUNT * COLORS_PER_PAL * 2,
    localparam int         IDX_W          = $clog2(ENTRIES),
    localparam int         PSEL_W         = $clog2(PAL_COUNT),
    localparam int         CIDX_W         = $clog2(COLORS_PER_PAL)
) (
    input  logic                        I_CLK,
    input  logic                        I_RESET,
    input  logic [15:0]                 I_MEMBUS_ADDR,
    input  logic [7:0]                  I_DATA,
    input  logic                        I_MEMBUS_WE_L,
    output logic [7:0]                  O_DATA,
    output logic                        O_IS_CF_ADDR,
    input  logic                        I_PPU_LOCK,
    input  logic [NUM_BANKS-1:0]        I_PPU_REQ,
    input  logic [NUM_BANKS*PSEL_W-1:0] I_PPU_PAL_SEL,
    input  logic [NUM_BANKS*CIDX_W-1:0] I_PPU_CIDX,
    output logic [NUM_BANKS*16-1:0]     O_PPU_COLOR,
    output logic [NUM_BANKS-1:0]        O_PPU_VALID,
    output logic                        O_INIT_BUSY
);

    logic [NUM_BANKS-1:0]   spec_hit;
    logic [NUM_BANKS-1:0]   data_hit;
    logic [NUM_BANKS-1:0]   auto_inc;
    logic [IDX_W-1:0]       idx [NUM_BANKS];
    logic [7:0]             mem [NUM_BANKS][ENTRIES];
    logic [IDX_W-1:0]       lk_even [NUM_BANKS];
    logic [IDX_W-1:0]       lk_odd [NUM_BANKS];
    logic [NUM_BANKS*16-1:0] color_q;
    logic [NUM_BANKS-1:0]   valid_q;
    logic                   clearing;
    logic [IDX_W-1:0]       clr_idx;
    logic                   wr_en;
    logic [7:0]             spec_rd;
    logic                   unused_data;

    // Only the flag bit and the index bits of a spec write are stored.
    assign unused_data = ^I_DATA;
    assign wr_en       = ~I_MEMBUS_WE_L;

`ifdef PAL_INIT_CLEAR_EN
    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

    clr_state_t       state;
    clr_state_t       state_nxt;
    logic [IDX_W-1:0] clr_idx_nxt;

    // Clear sequencer state register; reset (re)starts the sweep at entry 0.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Clear sequencer next state: one entry per cycle, back to idle after the last.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            ST_CLEAR: begin
                if (clr_idx == IDX_W'(ENTRIES - 1)) begin
                    state_nxt   = ST_IDLE;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                clr_idx_nxt = '0;
            end
        endcase
    end

    assign clearing = (state == ST_CLEAR);
`else
    assign clearing = 1'b0;
    assign clr_idx  = '0;
`endif

    assign O_INIT_BUSY = clearing;

    // Address decode and CPU read mux; unowned addresses read as zero.
    always_comb begin
        spec_hit = '0;
        data_hit = '0;
        O_DATA   = 8'h00;
        spec_rd  = 8'hFF;
        for (int b = 0; b < NUM_BANKS; b++) begin
            spec_hit[b] = (I_MEMBUS_ADDR == BASE_ADDR + 16'(2 * b));
            data_hit[b] = (I_MEMBUS_ADDR == BASE_ADDR + 16'(2 * b + 1));
            if (spec_hit[b]) begin
                spec_rd              = 8'hFF;
                spec_rd[7]           = auto_inc[b];
                spec_rd[IDX_W-1:0]   = idx[b];
                O_DATA               = spec_rd;
            end
            if (data_hit[b]) begin
                O_DATA = (I_PPU_LOCK || clearing) ? 8'hFF : mem[b][idx[b]];
            end
        end
        O_IS_CF_ADDR = (|spec_hit) | (|data_hit);
    end

    // PPU lookup indices: the even byte of a colour holds bits [15:8].
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            lk_even[b] = {I_PPU_PAL_SEL[b*PSEL_W +: PSEL_W], I_PPU_CIDX[b*CIDX_W +: CIDX_W], 1'b0};
            lk_odd[b]  = {I_PPU_PAL_SEL[b*PSEL_W +: PSEL_W], I_PPU_CIDX[b*CIDX_W +: CIDX_W], 1'b1};
        end
    end

    // Spec registers; auto-increment still advances under the PPU lock but not while clearing.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                auto_inc[b] <= 1'b0;
                idx[b]      <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (wr_en && spec_hit[b]) begin
                    auto_inc[b] <= I_DATA[7];
                    idx[b]      <= I_DATA[IDX_W-1:0];
                end else if (wr_en && data_hit[b] && !clearing && auto_inc[b]) begin
                    idx[b] <= (idx[b] == IDX_W'(ENTRIES - 1)) ? '0 : idx[b] + 1'b1;
                end
            end
        end
    end

    // Palette storage; contents survive reset, only the clear sweep fills them.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (clearing) begin
                    mem[b][clr_idx] <= 8'hFF;
                end else if (wr_en && data_hit[b] && !I_PPU_LOCK) begin
                    mem[b][idx[b]] <= I_DATA;
                end
            end
        end
    end

    // Registered PPU lookups; a same-cycle CPU write is seen by the following lookup.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            color_q <= '0;
            valid_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                valid_q[b] <= I_PPU_REQ[b];
                if (I_PPU_REQ[b]) begin
                    color_q[b*16 +: 16] <= clearing ? 16'hFFFF : {mem[b][lk_even[b]], mem[b][lk_odd[b]]};
                end
            end
        end
    end

    assign O_PPU_COLOR = color_q;
    assign O_PPU_VALID = valid_q;

endmodule

// File: tb/tb_cgb_palette_file.sv
// Purpose: self-checking bench for cgb_palette_file against a behavioural palette model.
// Latency: model mirrors registered PPU lookups one cycle after request; CPU reads checked combinationally.
// Backpressure: exercises PPU lock and, when PAL_INIT_CLEAR_EN is defined, the clear sweep.
module tb_cgb_palette_file;

    localparam int NB  = 2;
    localparam int ENT = 64;

    logic        I_CLK = 1'b0;
    logic        I_RESET;
    logic [15:0] I_MEMBUS_ADDR;
    logic [7:0]  I_DATA;
    logic        I_MEMBUS_WE_L;
    logic [7:0]  O_DATA;
    logic        O_IS_CF_ADDR;
    logic        I_PPU_LOCK;
    logic [1:0]  I_PPU_REQ;
    logic [5:0]  I_PPU_PAL_SEL;
    logic [3:0]  I_PPU_CIDX;
    logic [31:0] O_PPU_COLOR;
    logic [1:0]  O_PPU_VALID;
    logic        O_INIT_BUSY;

    cgb_palette_file dut (
        .I_CLK         (I_CLK),
        .I_RESET       (I_RESET),
        .I_MEMBUS_ADDR (I_MEMBUS_ADDR),
        .I_DATA        (I_DATA),
        .I_MEMBUS_WE_L (I_MEMBUS_WE_L),
        .O_DATA        (O_DATA),
        .O_IS_CF_ADDR  (O_IS_CF_ADDR),
        .I_PPU_LOCK    (I_PPU_LOCK),
        .I_PPU_REQ     (I_PPU_REQ),
        .I_PPU_PAL_SEL (I_PPU_PAL_SEL),
        .I_PPU_CIDX    (I_PPU_CIDX),
        .O_PPU_COLOR   (O_PPU_COLOR),
        .O_PPU_VALID   (O_PPU_VALID),
        .O_INIT_BUSY   (O_INIT_BUSY)
    );

    always #5 I_CLK = ~I_CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte arrays per bank, knowledge bits for unwritten entries.
    logic [7:0]  m [NB][ENT];
    bit          kn [NB][ENT];
    bit          flg [NB];
    int          ix [NB];
    logic [15:0] ecol [NB];
    bit          ekn [NB] = '{0, 0};
    bit          evld [NB];
    bit          clr_on = 0;
    int          clr_k = 0;
    bit          chk_en = 0;
    bit          clr_now;
    int          e;

    always @(posedge I_CLK) begin
        if (I_RESET) begin
            for (int b = 0; b < NB; b++) begin
                flg[b]  = 0;
                ix[b]   = 0;
                ecol[b] = 16'h0000;
                ekn[b]  = 1;
                evld[b] = 0;
            end
`ifdef PAL_INIT_CLEAR_EN
            clr_on = 1;
            clr_k  = 0;
`endif
        end else begin
            clr_now = clr_on;
            for (int b = 0; b < NB; b++) begin
                if (I_PPU_REQ[b]) begin
                    e = int'(I_PPU_PAL_SEL[b*3 +: 3]) * 8 + int'(I_PPU_CIDX[b*2 +: 2]) * 2;
                    evld[b] = 1;
                    if (clr_now) begin
                        ecol[b] = 16'hFFFF;
                        ekn[b]  = 1;
                    end else begin
                        ecol[b] = {m[b][e], m[b][e+1]};
                        ekn[b]  = kn[b][e] && kn[b][e+1];
                    end
                end else begin
                    evld[b] = 0;
                end
            end
            if (!I_MEMBUS_WE_L) begin
                for (int b = 0; b < NB; b++) begin
                    if (I_MEMBUS_ADDR == 16'hFF68 + 16'(2 * b)) begin
                        flg[b] = I_DATA[7];
                        ix[b]  = int'(I_DATA) % ENT;
                    end
                    if (I_MEMBUS_ADDR == 16'hFF69 + 16'(2 * b) && !clr_now) begin
                        if (!I_PPU_LOCK) begin
                            m[b][ix[b]]  = I_DATA;
                            kn[b][ix[b]] = 1;
                        end
                        if (flg[b]) ix[b] = (ix[b] + 1) % ENT;
                    end
                end
            end
            if (clr_now) begin
                for (int b = 0; b < NB; b++) begin
                    m[b][clr_k]  = 8'hFF;
                    kn[b][clr_k] = 1;
                end
                clr_k++;
                if (clr_k == ENT) begin
                    clr_on = 0;
                    clr_k  = 0;
                end
            end
        end
    end

    // Compare process: every cycle after the first reset.
    logic [7:0] ed;
    bit         hit;
    bit         dk;
    always @(negedge I_CLK) begin
        if (chk_en) begin
            chk("init_busy", {31'd0, O_INIT_BUSY}, {31'd0, clr_on});
            chk("ppu_valid", {30'd0, O_PPU_VALID}, {30'd0, evld[1], evld[0]});
            for (int b = 0; b < NB; b++) begin
                if (ekn[b]) chk("ppu_color", {16'd0, O_PPU_COLOR[b*16 +: 16]}, {16'd0, ecol[b]});
            end
            hit = 0;
            dk  = 1;
            ed  = 8'h00;
            for (int b = 0; b < NB; b++) begin
                if (I_MEMBUS_ADDR == 16'hFF68 + 16'(2 * b)) begin
                    hit = 1;
                    ed  = (flg[b] ? 8'h80 : 8'h00) | 8'h40 | 8'(ix[b]);
                end
                if (I_MEMBUS_ADDR == 16'hFF69 + 16'(2 * b)) begin
                    hit = 1;
                    if (I_PPU_LOCK || clr_on) ed = 8'hFF;
                    else if (kn[b][ix[b]]) ed = m[b][ix[b]];
                    else dk = 0;
                end
            end
            chk("is_cf_addr", {31'd0, O_IS_CF_ADDR}, {31'd0, hit});
            if (dk) chk("o_data", {24'd0, O_DATA}, {24'd0, ed});
        end
    end

    task automatic tick();
        @(posedge I_CLK);
        #2;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        I_MEMBUS_ADDR = a;
        I_DATA        = d;
        I_MEMBUS_WE_L = 1'b0;
        tick();
        I_MEMBUS_WE_L = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        I_MEMBUS_ADDR = a;
        I_MEMBUS_WE_L = 1'b1;
        #1;
        chk(name, {24'd0, O_DATA}, {24'd0, exp});
    endtask

    task automatic pulse_reset();
        I_RESET = 1'b1;
        tick();
        I_RESET = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (O_INIT_BUSY && n < 200) begin
            tick();
            n++;
        end
        if (O_INIT_BUSY) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        int r;
        I_RESET       = 1'b1;
        I_MEMBUS_ADDR = 16'h0000;
        I_DATA        = 8'h00;
        I_MEMBUS_WE_L = 1'b1;
        I_PPU_LOCK    = 1'b0;
        I_PPU_REQ     = 2'b00;
        I_PPU_PAL_SEL = '0;
        I_PPU_CIDX    = '0;
        tick();
        chk_en = 1;
        tick();
        I_RESET = 1'b0;
        chk("rst_valid", {30'd0, O_PPU_VALID}, 32'd0);
        chk("rst_color", O_PPU_COLOR, 32'd0);
        rd_chk("rst_spec0", 16'hFF68, 8'h40);
        rd_chk("rst_spec1", 16'hFF6A, 8'h40);
        wait_idle();

        // Fill both banks with a known pattern through auto-increment.
        for (int b = 0; b < NB; b++) begin
            bus_wr(16'hFF68 + 16'(2 * b), 8'h80);
            for (int k = 0; k < ENT; k++) bus_wr(16'hFF69 + 16'(2 * b), 8'(b * 64 + k));
        end

        // Auto-increment and colour assembly.
        bus_wr(16'hFF68, 8'h80);
        bus_wr(16'hFF69, 8'h11);
        bus_wr(16'hFF69, 8'h22);
        bus_wr(16'hFF69, 8'h33);
        bus_wr(16'hFF69, 8'h44);
        rd_chk("t1_spec", 16'hFF68, 8'hC4);
        I_PPU_REQ = 2'b01; I_PPU_PAL_SEL = 6'd0; I_PPU_CIDX = 4'd0;
        tick();
        chk("t1_col0", {16'd0, O_PPU_COLOR[15:0]}, 32'h1122);
        chk("t1_vld", {30'd0, O_PPU_VALID}, 32'd1);
        I_PPU_CIDX = 4'd1;
        tick();
        chk("t1_col1", {16'd0, O_PPU_COLOR[15:0]}, 32'h3344);
        I_PPU_REQ = 2'b00;

        // Bank 1 wrap at the last entry.
        bus_wr(16'hFF6A, 8'hBF);
        bus_wr(16'hFF6B, 8'hAA);
        bus_wr(16'hFF6B, 8'hBB);
        rd_chk("t2_spec", 16'hFF6A, 8'hC1);
        bus_wr(16'hFF6A, 8'h3F);
        rd_chk("t2_b63", 16'hFF6B, 8'hAA);
        bus_wr(16'hFF6A, 8'h00);
        rd_chk("t2_b0", 16'hFF6B, 8'hBB);
        bus_wr(16'hFF68, 8'h00);
        rd_chk("t2_bank0", 16'hFF69, 8'h11);

        // PPU lock.
        bus_wr(16'hFF68, 8'h86);
        I_PPU_LOCK = 1'b1;
        bus_wr(16'hFF69, 8'h55);
        rd_chk("t3_spec", 16'hFF68, 8'hC7);
        rd_chk("t3_lockrd", 16'hFF69, 8'hFF);
        I_PPU_LOCK = 1'b0;
        rd_chk("t3_b7", 16'hFF69, 8'h07);
        bus_wr(16'hFF68, 8'h06);
        rd_chk("t3_b6", 16'hFF69, 8'h06);

        // Same-cycle write and lookup.
        bus_wr(16'hFF6A, 8'h88);
        I_MEMBUS_ADDR = 16'hFF6B; I_DATA = 8'h99; I_MEMBUS_WE_L = 1'b0;
        I_PPU_REQ = 2'b10; I_PPU_PAL_SEL = {3'd1, 3'd0}; I_PPU_CIDX = 4'd0;
        tick();
        I_MEMBUS_WE_L = 1'b1;
        chk("t4_old", {16'd0, O_PPU_COLOR[31:16]}, 32'h4849);
        chk("t4_vld", {30'd0, O_PPU_VALID}, 32'd2);
        tick();
        chk("t4_new", {16'd0, O_PPU_COLOR[31:16]}, 32'h9949);

        // Both banks together, then hold.
        I_PPU_REQ = 2'b11; I_PPU_PAL_SEL = {3'd5, 3'd2}; I_PPU_CIDX = {2'd3, 2'd1};
        tick();
        chk("t5_vld", {30'd0, O_PPU_VALID}, 32'd3);
        chk("t5_col", O_PPU_COLOR, 32'h6E6F1213);
        I_PPU_REQ = 2'b00;
        tick();
        chk("t5_vld_lo", {30'd0, O_PPU_VALID}, 32'd0);
        chk("t5_hold", O_PPU_COLOR, 32'h6E6F1213);

        // Mid-operation reset.
        I_PPU_REQ = 2'b11;
        pulse_reset();
        I_PPU_REQ = 2'b00;
        chk("t6_color", O_PPU_COLOR, 32'd0);
        chk("t6_vld", {30'd0, O_PPU_VALID}, 32'd0);
        rd_chk("t6_spec", 16'hFF68, 8'h40);
`ifdef PAL_INIT_CLEAR_EN
        bus_wr(16'hFF68, 8'h80);
        bus_wr(16'hFF69, 8'h77);
        n = 2;
        while (O_INIT_BUSY && n < 200) begin
            tick();
            n++;
        end
        chk("clr_len", n, 32'd64);
        rd_chk("clr_noinc", 16'hFF68, 8'hC0);
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 4; c++) begin
                I_PPU_REQ = 2'b11; I_PPU_PAL_SEL = {3'(7 - s), 3'(s)}; I_PPU_CIDX = {2'(c), 2'(3 - c)};
                tick();
                chk("clr_ffff", O_PPU_COLOR, 32'hFFFFFFFF);
            end
        end
        I_PPU_REQ = 2'b00;
        pulse_reset();
        for (int k = 0; k < 19; k++) tick();
        pulse_reset();
        n = 0;
        while (O_INIT_BUSY && n < 200) begin
            tick();
            n++;
        end
        chk("clr_restart_len", n, 32'd64);
`else
        chk("busy_tied", {31'd0, O_INIT_BUSY}, 32'd0);
`endif

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4) I_MEMBUS_ADDR = 16'hFF68 + 16'(r);
            else if (r == 4) I_MEMBUS_ADDR = 16'hFF67;
            else if (r == 5) I_MEMBUS_ADDR = 16'hFF6C;
            else I_MEMBUS_ADDR = 16'($urandom);
            I_MEMBUS_WE_L = 1'($urandom_range(0, 1));
            I_DATA        = 8'($urandom);
            I_PPU_LOCK    = ($urandom_range(0, 4) == 0);
            I_PPU_REQ     = 2'($urandom);
            I_PPU_PAL_SEL = 6'($urandom);
            I_PPU_CIDX    = 4'($urandom);
            I_RESET       = ($urandom_range(0, 199) == 0);
            tick();
        end
        I_RESET = 1'b0;
        I_MEMBUS_WE_L = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
